// File: rtl/seq_pkg.sv
// Shared types and constants for the serial pattern generator and its detector peers.
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Pattern width the detector side is built for.
  localparam int SEQ_PAT_W = 4;

  function automatic int idx_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/seq_gen_shifter.sv
// Purpose: PAT_W-bit load/shift register (MSB first) with bit_idx down-counter.
// Latency: load/shift take effect on the next edge. Backpressure: none, driven by the FSM.
module seq_gen_shifter
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int IDX_W = idx_width(PAT_W)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift_en,
  input  logic [PAT_W-1:0] load_dat,
  output logic             next_bit,
  output logic             last
);

  logic [PAT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

  always_comb begin
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    if (load) begin
      shift_d   = load_dat;
      bit_idx_d = IDX_W'(PAT_W - 1);
    end else if (shift_en) begin
      shift_d = {shift_q[PAT_W-2:0], 1'b0};
      if (bit_idx_q != '0) begin
        bit_idx_d = bit_idx_q - IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q   <= '0;
      bit_idx_q <= '0;
    end else begin
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
    end
  end

  // Bit that follows the one currently on the line, so the top can register dout.
  assign next_bit = shift_q[PAT_W-2];
  assign last     = (bit_idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// Purpose: serial MSB-first pattern transmitter; SEQ_GEN_REPEAT_EN enables back-to-back repeats.
// Latency: first bit one cycle after start is accepted; all outputs registered.
// Backpressure: start honoured only while ready=1, otherwise dropped. Port repeat_cnt carries
// the repeat count ("repeat" is a reserved word).
module seq_pattern_gen
  import seq_pkg::*;
#(
  parameter int PAT_W = SEQ_PAT_W,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [REP_W-1:0] repeat_cnt,
  output logic             ready,
  output logic             dout,
  output logic             valid,
  output logic             done
);

  state_e           state_q, state_d;
  logic             ready_q, ready_d;
  logic             dout_q, dout_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             load, shift_en, next_bit, last;
  logic [PAT_W-1:0] load_dat;

`ifdef SEQ_GEN_REPEAT_EN
  logic [PAT_W-1:0] hold_q, hold_d;
  logic [REP_W-1:0] reps_left_q, reps_left_d;
`else
  logic unused_repeat;
  assign unused_repeat = ^repeat_cnt;
`endif

  seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift_en (shift_en),
    .load_dat (load_dat),
    .next_bit (next_bit),
    .last     (last)
  );

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    shift_en = 1'b0;
    load_dat = pattern;
`ifdef SEQ_GEN_REPEAT_EN
    hold_d      = hold_q;
    reps_left_d = reps_left_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = SHIFT;
`ifdef SEQ_GEN_REPEAT_EN
          hold_d      = pattern;
          reps_left_d = repeat_cnt;
`endif
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last) begin
`ifdef SEQ_GEN_REPEAT_EN
          if (reps_left_q != '0) begin
            load        = 1'b1;
            load_dat    = hold_q;
            reps_left_d = reps_left_q - REP_W'(1);
          end else begin
            state_d = DONE;
          end
`else
          state_d = DONE;
`endif
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are computed for the state being entered so they can be registered.
    ready_d = (state_d == IDLE);
    valid_d = (state_d == SHIFT);
    done_d  = (state_d == DONE);
    dout_d  = 1'b0;
    if (state_d == SHIFT) begin
      dout_d = load ? load_dat[PAT_W-1] : next_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      dout_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_GEN_REPEAT_EN
      hold_q      <= '0;
      reps_left_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
      done_q  <= done_d;
`ifdef SEQ_GEN_REPEAT_EN
      hold_q      <= hold_d;
      reps_left_q <= reps_left_d;
`endif
    end
  end

  assign ready = ready_q;
  assign dout  = dout_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_seq_pattern_gen.sv
// Scoreboard bench for seq_pattern_gen: stimulus queues expected bits/done, a monitor checks them.
module tb_seq_pattern_gen;

  localparam int PAT_W = 4;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [REP_W-1:0] repeat_cnt;
  logic             ready, dout, valid, done;

  typedef struct packed {
    logic is_done;
    logic dat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  bit   allow_gap = 1'b0;
  bit   in_stream = 1'b0;

  seq_pattern_gen #(.PAT_W(PAT_W), .REP_W(REP_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .ready      (ready),
    .dout       (dout),
    .valid      (valid),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output cycle consumes one scoreboard entry; gaps inside a job are errors.
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid === 1'b1 || done === 1'b1) begin
        check("valid_done_exclusive", valid & done, 1'b0);
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got valid=%b done=%b expected none at %0t",
                   valid, done, $time);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (e.is_done) begin
            check("done_pulse", done, 1'b1);
            in_stream = 1'b0;
          end else begin
            check("valid_bit", valid, 1'b1);
            check("dout_bit", dout, e.dat);
            in_stream = 1'b1;
          end
        end
      end else if (in_stream) begin
        in_stream = 1'b0;
        if (!allow_gap) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_gap: got idle cycle expected bit/done (%0d pending) at %0t",
                   q.size(), $time);
        end
      end
    end
  end

  task automatic push_job(input logic [PAT_W-1:0] pat, input int reps);
    exp_t e;
    for (int r = 0; r <= reps; r++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e.is_done = 1'b0;
        e.dat     = pat[b];
        q.push_back(e);
      end
    end
    e.is_done = 1'b1;
    e.dat     = 1'b0;
    q.push_back(e);
  endtask

  task automatic issue(input logic [PAT_W-1:0] pat, input logic [REP_W-1:0] rep, input int exp_reps);
    pattern    = pat;
    repeat_cnt = rep;
    start      = 1'b1;
    push_job(pat, exp_reps);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      if (ready === 1'b1 && q.size() == 0) return;
      @(posedge clk); #1;
    end
    n_cmp++;
    n_bad++;
    $display("FAIL %s_timeout: got ready=%b pending=%0d expected idle", name, ready, q.size());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   rep_exp;
    reset      = 1'b1;
    start      = 1'b0;
    pattern    = '0;
    repeat_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 3; i++) begin
      check("rst_ready", ready, 1'b1);
      check("rst_valid", valid, 1'b0);
      check("rst_dout",  dout,  1'b0);
      check("rst_done",  done,  1'b0);
      @(posedge clk); #1;
    end

    // Single pattern: done after 4 bits, ready the cycle after done.
    issue(4'b1000, 4'd0, 0);
    check("busy_ready", ready, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check("done_cycle_ready", ready, 1'b0);
    check("done_cycle_done", done, 1'b1);
    @(posedge clk); #1;
    check("ready_return", ready, 1'b1);
    wait_idle("single");

`ifdef SEQ_GEN_REPEAT_EN
    rep_exp = 2;
`else
    rep_exp = 0;
`endif
    issue(4'b1011, 4'd2, rep_exp);
    wait_idle("repeat");

    // start and pattern change mid-job must not disturb the stream.
    issue(4'b1001, 4'd0, 0);
    pattern = 4'b0110;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle("ignored_start");

    // Reset after the second bit abandons the job without done.
    pattern    = 4'b1100;
    repeat_cnt = '0;
    start      = 1'b1;
    for (int b = 0; b < 2; b++) begin
      e.is_done = 1'b0;
      e.dat     = 1'b1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    reset     = 1'b1;
    allow_gap = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_valid", valid, 1'b0);
    check("abort_ready", ready, 1'b1);
    check("abort_done",  done,  1'b0);
    repeat (6) @(posedge clk);
    #1;
    allow_gap = 1'b0;
    issue(4'b0101, 4'd0, 0);
    wait_idle("after_abort");

    // All-zero pattern: valid alone frames the data.
    issue(4'b0000, 4'd0, 0);
    wait_idle("zero_pattern");

    repeat (4) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL leftover: got %0d pending entries expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
